// File: rtl/burst_capture_ctrl_pkg.sv
// Shared types and helpers for the burst capture controller.
package burst_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  // Width of the channel select; never narrower than one bit.
  function automatic int unsigned ch_sel_w(input int unsigned num_ch);
    int unsigned w;
    w = 1;
    if (num_ch > 1) w = $clog2(num_ch);
    return w;
  endfunction

endpackage

// File: rtl/burst_capture_ctrl_if.sv
// Sample stream in and RAM write port out of the capture controller.
interface burst_capture_ctrl_if #(
  parameter int unsigned SAMPLE_W = 33,
  parameter int unsigned BURST    = 5,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 12
);
  logic                         sample_valid;
  logic [NUM_CH*SAMPLE_W-1:0]   sample_data;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [BURST*SAMPLE_W-1:0]    mem_wdata;

  modport master (
    input  sample_valid, sample_data,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output sample_valid, sample_data,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/burst_capture_ctrl_packer.sv
// Slot counter and shift register packing BURST samples into one RAM word.
module burst_packer #(
  parameter int unsigned SAMPLE_W = 33,
  parameter int unsigned BURST    = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      accept,
  input  logic [SAMPLE_W-1:0]       sample,
  output logic                      word_valid,
  output logic [BURST*SAMPLE_W-1:0] word
);

  localparam int unsigned CNT_W  = $clog2(BURST);
  localparam int unsigned WORD_W = BURST * SAMPLE_W;

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] sr_next_c;
  logic              last_slot_c;

  // New samples enter at the top so the first sample ends in slot 0.
  assign sr_next_c   = {sample, sr[WORD_W-1:SAMPLE_W]};
  assign last_slot_c = (cnt == CNT_W'(BURST - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (accept) begin
        sr <= sr_next_c;
        if (last_slot_c) begin
          cnt        <= '0;
          word       <= sr_next_c;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/burst_capture_ctrl.sv
// Capture controller: packs one channel into RAM words, one-shot or trigger-stopped ring.
module burst_capture_ctrl
  import burst_capture_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 33,
  parameter int unsigned BURST    = 5,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        mode,
  input  logic [ch_sel_w(NUM_CH)-1:0] ch_sel,
  input  logic [ADDR_W-1:0]           post_trig,
  input  logic                        trigger,
  burst_capture_ctrl_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        wrapped,
  output logic [ADDR_W-1:0]           trig_addr,
  output logic [ADDR_W-1:0]           last_addr
);

  localparam int unsigned CH_W   = ch_sel_w(NUM_CH);
  localparam int unsigned WORD_W = BURST * SAMPLE_W;
  localparam int unsigned REM_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic                mode_q;
  logic [CH_W-1:0]     ch_q;
  logic [ADDR_W-1:0]   post_q;
  logic [ADDR_W-1:0]   addr;
  logic [REM_W-1:0]    remain;
  logic                word_valid;
  logic [WORD_W-1:0]   word;
  logic                active_c;
  logic                accept_c;
  logic                clear_c;
  logic [SAMPLE_W-1:0] sel_sample_c;
  logic [ADDR_W-1:0]   next_addr_c;
  logic [ADDR_W-1:0]   pack_addr_c;

  // Abort blocks acceptance so a word completing alongside it is never written.
  assign active_c    = (state == ST_CAPTURE) || (state == ST_POST);
  assign accept_c    = active_c && bus.sample_valid && !abort;
  assign clear_c     = abort || (start && !active_c);
  assign next_addr_c = (addr == LAST_A) ? '0 : addr + ADDR_W'(1);
  // While a write is being issued the packer already fills the following word.
  assign pack_addr_c = word_valid ? next_addr_c : addr;

  assign bus.mem_we    = word_valid;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = word;

  always_comb begin
    sel_sample_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) sel_sample_c = bus.sample_data[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  burst_packer #(.SAMPLE_W(SAMPLE_W), .BURST(BURST)) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear_c),
    .accept     (accept_c),
    .sample     (sel_sample_c),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_ONESHOT;
      ch_q      <= '0;
      post_q    <= '0;
      addr      <= '0;
      remain    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrapped   <= 1'b0;
      trig_addr <= '0;
      last_addr <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_CAPTURE;
            busy    <= 1'b1;
            done    <= 1'b0;
            wrapped <= 1'b0;
            addr    <= '0;
            mode_q  <= mode;
            ch_q    <= ch_sel;
            post_q  <= post_trig;
          end
        end
        ST_CAPTURE: begin
          if (word_valid) begin
            if ((mode_q == MODE_ONESHOT) && (addr == LAST_A)) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              last_addr <= addr;
            end else begin
              addr <= next_addr_c;
              if (addr == LAST_A) wrapped <= 1'b1;
            end
          end
          // Remaining count covers the trigger word plus post_trig more.
          if ((mode_q == MODE_RING) && trigger) begin
            state     <= ST_POST;
            trig_addr <= pack_addr_c;
            remain    <= {1'b0, post_q} + REM_W'(1);
          end
        end
        ST_POST: begin
          if (word_valid) begin
            if (remain == REM_W'(1)) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              last_addr <= addr;
            end else begin
              remain <= remain - REM_W'(1);
              addr   <= next_addr_c;
              if (addr == LAST_A) wrapped <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
